// File: rtl/fifo_unpacker_if.sv
// Handshake bundle for fifo_unpacker: show-ahead FIFO read port plus narrow valid/ready stream.
// The unpacker takes the master side; the FIFO and consumer together take the slave side.
interface fifo_unpacker_if #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned OUT_WIDTH = 32
) ();

  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_rd_data;
  logic                 fifo_rd;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  out_ready,
    output fifo_rd,
    output out_valid,
    output out_data,
    output out_last
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output out_ready,
    input  fifo_rd,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/fifo_unpacker.sv
// Drains WIDTH-bit words from a show-ahead FIFO and emits them as OUT_WIDTH-bit beats,
// least-significant slice first, with back-to-back word reload on the final beat.
module fifo_unpacker #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_unpacker_if.master       bus,
  output logic                  busy_o,
  output logic [15:0]           words_drained_o
);

  localparam int unsigned BEATS = WIDTH / OUT_WIDTH;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [15:0]       drained_q, drained_d;

  logic sending;
  logic last_beat;
  logic accept;
  logic pop;

  always_comb begin
    sending   = (state_q == StSend);
    last_beat = sending && (beat_q == LastBeat);
    accept    = sending && bus.out_ready;
    // Pop only when a slot frees up this cycle, and never while the FIFO is empty or in reset.
    pop       = !rst && !bus.fifo_empty && (!sending || (accept && last_beat));
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    beat_d    = beat_q;
    drained_d = drained_q + 16'(pop);

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shreg_d = bus.fifo_rd_data;
          beat_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          if (!last_beat) begin
            shreg_d = shreg_q >> OUT_WIDTH;
            beat_d  = beat_q + BW'(1);
          end else if (pop) begin
            shreg_d = bus.fifo_rd_data;
            beat_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      beat_q    <= '0;
      drained_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      beat_q    <= beat_d;
      drained_q <= drained_d;
    end
  end

  // Data is gated so an idle engine never shows a stale slice of the previous word.
  assign bus.out_valid   = sending;
  assign bus.out_data    = sending ? shreg_q[OUT_WIDTH-1:0] : '0;
  assign bus.out_last    = last_beat;
  assign bus.fifo_rd     = pop;
  assign busy_o          = sending;
  assign words_drained_o = drained_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(bus.fifo_rd && bus.fifo_empty));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last)));

endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: a queue-based FIFO, a beats-remaining reference model and
// directed plus random scenarios on a 256/32 instance and a single-beat 64/64 instance.
module tb_fifo_unpacker;

  localparam int unsigned WA = 256;
  localparam int unsigned OA = 32;
  localparam int unsigned BA = WA / OA;
  localparam int unsigned WB = 64;
  localparam int unsigned OB = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_unpacker_if #(.WIDTH(WA), .OUT_WIDTH(OA)) bus_a ();
  fifo_unpacker_if #(.WIDTH(WB), .OUT_WIDTH(OB)) bus_b ();

  logic        busy_a, busy_b;
  logic [15:0] wd_a, wd_b;

  fifo_unpacker #(.WIDTH(WA), .OUT_WIDTH(OA)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_a),
    .busy_o          (busy_a),
    .words_drained_o (wd_a)
  );

  fifo_unpacker #(.WIDTH(WB), .OUT_WIDTH(OB)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_b),
    .busy_o          (busy_b),
    .words_drained_o (wd_b)
  );

  int tests = 0;
  int fails = 0;

  // Environment FIFOs and stream readiness.
  logic [WA-1:0] fq_a[$];
  logic [WB-1:0] fq_b[$];
  logic ready_a = 1'b0;
  logic ready_b = 1'b0;

  // Reference model: beats remaining of the held word, the word itself, pop count.
  int            held_a, held_b;
  logic [WA-1:0] word_a;
  logic [WB-1:0] word_b;
  int unsigned   cnt_a, cnt_b;

  // Observation logs.
  int          cyc = 0;
  int          rd_cnt_a, first_rd_a, last_rd_a, first_valid_a, run_a, max_run_a;
  int          lasts_a, last_pos_a;
  logic [OA-1:0] beats_a[$];
  logic        prev_stall_a;
  logic [OA-1:0] prev_data_a;
  logic        prev_last_a;
  int unsigned acc_last_b, acc_nolast_b;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus_a.fifo_empty   = (fq_a.size() == 0);
    bus_a.fifo_rd_data = (fq_a.size() != 0) ? fq_a[0] : '0;
    bus_a.out_ready    = ready_a;
    bus_b.fifo_empty   = (fq_b.size() == 0);
    bus_b.fifo_rd_data = (fq_b.size() != 0) ? fq_b[0] : '0;
    bus_b.out_ready    = ready_b;
  endtask

  task automatic model_reset();
    held_a = 0; held_b = 0; cnt_a = 0; cnt_b = 0;
    word_a = '0; word_b = '0;
    prev_stall_a = 1'b0;
  endtask

  task automatic clear_logs();
    rd_cnt_a = 0; first_rd_a = -1; last_rd_a = -1; first_valid_a = -1;
    run_a = 0; max_run_a = 0; lasts_a = 0; last_pos_a = -1;
    beats_a.delete();
    acc_last_b = 0; acc_nolast_b = 0;
  endtask

  // One clock: compare against the model before the edge, advance model and FIFOs after it.
  task automatic cycle();
    logic exp_rd_a, exp_rd_b, seen_rd_a, seen_rd_b;
    drive();
    #1;
    exp_rd_a = !rst && (fq_a.size() != 0) && (held_a == 0 || (held_a == 1 && ready_a));
    exp_rd_b = !rst && (fq_b.size() != 0) && (held_b == 0 || ready_b);

    chk("a_fifo_rd", bus_a.fifo_rd, exp_rd_a);
    chk("a_valid", bus_a.out_valid, held_a > 0);
    chk("a_last", bus_a.out_last, held_a == 1);
    chk("a_busy", busy_a, held_a > 0);
    chk("a_words_drained", wd_a, 16'(cnt_a));
    if (held_a > 0) chk("a_data", bus_a.out_data, word_a[(BA - held_a) * OA +: OA]);
    if (prev_stall_a && !rst) begin
      chk("a_stall_data", bus_a.out_data, prev_data_a);
      chk("a_stall_last", bus_a.out_last, prev_last_a);
    end
    prev_stall_a = bus_a.out_valid && !ready_a && !rst;
    prev_data_a  = bus_a.out_data;
    prev_last_a  = bus_a.out_last;

    chk("b_fifo_rd", bus_b.fifo_rd, exp_rd_b);
    chk("b_valid", bus_b.out_valid, held_b > 0);
    chk("b_last", bus_b.out_last, held_b > 0);
    chk("b_busy", busy_b, held_b > 0);
    chk("b_words_drained", wd_b, 16'(cnt_b));
    if (held_b > 0) chk("b_data", bus_b.out_data, word_b);

    if (bus_a.fifo_rd) begin
      rd_cnt_a++;
      if (first_rd_a < 0) first_rd_a = cyc;
      last_rd_a = cyc;
    end
    if (bus_a.out_valid) begin
      if (first_valid_a < 0) first_valid_a = cyc;
      run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
    end
    if (bus_a.out_valid && ready_a) begin
      beats_a.push_back(bus_a.out_data);
      if (bus_a.out_last) begin
        lasts_a++;
        last_pos_a = beats_a.size() - 1;
      end
    end
    if (bus_b.out_valid && ready_b) begin
      if (bus_b.out_last) acc_last_b++;
      else acc_nolast_b++;
    end
    seen_rd_a = bus_a.fifo_rd;
    seen_rd_b = bus_b.fifo_rd;

    @(posedge clk);
    #1;
    if (!rst) begin
      if (exp_rd_a) begin
        word_a = fq_a[0]; held_a = BA; cnt_a++;
      end else if (held_a > 0 && ready_a) begin
        held_a--;
      end
      if (exp_rd_b) begin
        word_b = fq_b[0]; held_b = 1; cnt_b++;
      end else if (held_b > 0 && ready_b) begin
        held_b = 0;
      end
    end
    if (seen_rd_a) begin
      chk("a_underflow", fq_a.size() == 0, 1'b0);
      if (fq_a.size() != 0) void'(fq_a.pop_front());
    end
    if (seen_rd_b) begin
      chk("b_underflow", fq_b.size() == 0, 1'b0);
      if (fq_b.size() != 0) void'(fq_b.pop_front());
    end
    drive();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [WA-1:0] rand_word();
    logic [WA-1:0] w;
    for (int i = 0; i < int'(WA / 32); i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WA-1:0] pat, w, w2;
    logic [OA-1:0] exp_beat;
    int unsigned   pushed_a, pushed_b;

    drive();
    model_reset();
    clear_logs();
    @(negedge clk);
    #1;
    chk("reset_valid", bus_a.out_valid, 1'b0);
    chk("reset_last", bus_a.out_last, 1'b0);
    chk("reset_data", bus_a.out_data, '0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_words_drained", wd_a, 16'h0000);
    @(negedge clk);
    do_reset();

    // Single word with byte-index pattern.
    clear_logs();
    for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
    fq_a.push_back(pat);
    ready_a = 1'b1;
    repeat (12) cycle();
    chk("t1_pops", rd_cnt_a, 1);
    chk("t1_nbeats", beats_a.size(), 8);
    if (beats_a.size() == 8) begin
      chk("t1_beat0", beats_a[0], 32'h03020100);
      chk("t1_beat7", beats_a[7], 32'h1f1e1d1c);
      for (int k = 0; k < 8; k++) begin
        exp_beat = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        chk("t1_beat_order", beats_a[k], exp_beat);
      end
    end
    chk("t1_lasts", lasts_a, 1);
    chk("t1_last_pos", last_pos_a, 7);
    chk("t1_latency", first_valid_a - first_rd_a, 1);
    chk("t1_words_drained", wd_a, 16'd1);
    chk("t1_idle", busy_a, 1'b0);

    // Back-to-back words.
    do_reset();
    clear_logs();
    repeat (3) fq_a.push_back(rand_word());
    ready_a = 1'b1;
    repeat (30) cycle();
    chk("t2_run", max_run_a, 24);
    chk("t2_pops", rd_cnt_a, 3);
    chk("t2_pop_span", last_rd_a - first_rd_a, 16);
    chk("t2_nbeats", beats_a.size(), 24);
    chk("t2_lasts", lasts_a, 3);
    chk("t2_words_drained", wd_a, 16'd3);

    // Backpressure 1,0,0 pattern.
    clear_logs();
    w = rand_word();
    fq_a.push_back(w);
    for (int i = 0; i < 40; i++) begin
      ready_a = (i % 3 == 0);
      cycle();
    end
    chk("t3_nbeats", beats_a.size(), 8);
    if (beats_a.size() == 8)
      for (int k = 0; k < 8; k++) chk("t3_beat", beats_a[k], w[k*OA +: OA]);
    chk("t3_lasts", lasts_a, 1);

    // Empty guard.
    clear_logs();
    for (int i = 0; i < 50; i++) begin
      ready_a = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("t4_no_pop_empty", rd_cnt_a, 0);
    chk("t4_idle", busy_a, 1'b0);
    fq_a.push_back(rand_word());
    ready_a = 1'b1;
    repeat (12) cycle();
    chk("t4_single_pop", rd_cnt_a, 1);
    chk("t4_nbeats", beats_a.size(), 8);

    // Random traffic on both instances.
    do_reset();
    clear_logs();
    pushed_a = 0;
    pushed_b = 0;
    for (int i = 0; i < 400; i++) begin
      if (fq_a.size() < 4 && $urandom_range(0, 3) == 0) begin
        fq_a.push_back(rand_word());
        pushed_a++;
      end
      if (fq_b.size() < 4 && $urandom_range(0, 1) == 0) begin
        fq_b.push_back({$urandom(), $urandom()});
        pushed_b++;
      end
      ready_a = 1'($urandom_range(0, 1));
      ready_b = 1'($urandom_range(0, 1));
      cycle();
    end
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (50) cycle();
    chk("t5_a_drained", fq_a.size(), 0);
    chk("t5_a_words", wd_a, 16'(pushed_a));
    chk("t5_a_beats", beats_a.size(), pushed_a * BA);
    chk("t5_b_words", wd_b, 16'(pushed_b));
    chk("t5_b_beats", acc_last_b, pushed_b);

    // Reset in the middle of a word.
    do_reset();
    clear_logs();
    w  = rand_word();
    w2 = rand_word();
    fq_a.push_back(w);
    fq_a.push_back(w2);
    ready_a = 1'b1;
    for (int i = 0; i < 20 && beats_a.size() < 3; i++) cycle();
    chk("t6_reached_beat3", beats_a.size(), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus_a.out_valid, 1'b0);
    chk("t6_rst_last", bus_a.out_last, 1'b0);
    chk("t6_rst_data", bus_a.out_data, '0);
    chk("t6_rst_busy", busy_a, 1'b0);
    chk("t6_rst_words", wd_a, 16'h0000);
    chk("t6_rst_fifo_rd", bus_a.fifo_rd, 1'b0);
    model_reset();
    fq_b.delete();
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;
    clear_logs();
    repeat (12) cycle();
    chk("t6_nbeats", beats_a.size(), 8);
    if (beats_a.size() == 8) begin
      chk("t6_beat0", beats_a[0], w2[31:0]);
      chk("t6_beat7", beats_a[7], w2[255:224]);
    end
    chk("t6_words", wd_a, 16'd1);

    // Single-beat instance: counter wrap over 0x10001 words.
    clear_logs();
    ready_a = 1'b0;
    ready_b = 1'b1;
    pushed_b = 0;
    for (int i = 0; i < 70000 && !(pushed_b == 32'h10001 && fq_b.size() == 0 && held_b == 0);
         i++) begin
      if (pushed_b < 32'h10001 && fq_b.size() < 3) begin
        fq_b.push_back({$urandom(), $urandom()});
        pushed_b++;
      end
      cycle();
    end
    chk("t7_model_pops", cnt_b, 32'h10001);
    chk("t7_words_wrap", wd_b, 16'h0001);
    chk("t7_all_last", acc_last_b, 32'h10001);
    chk("t7_no_nonlast", acc_nolast_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
